// File: rtl/pipe_ctrl_pkg.sv
// Shared stall codes, controller state encodings and stall-vector helpers for pipe_ctrl.
`default_nettype none
package pipe_ctrl_pkg;

  localparam logic [1:0] STALL_NEXT = 2'b00;
  localparam logic [1:0] STALL_KEEP = 2'b01;
  localparam logic [1:0] STALL_ZERO = 2'b10;

  localparam int REG_BUS = 64;

  localparam logic [0:0] PCTL_RUN   = 1'b0;
  localparam logic [0:0] PCTL_DRAIN = 1'b1;

  typedef struct packed {
    logic [1:0] pc;
    logic [1:0] if_id;
    logic [1:0] id_ex;
    logic [1:0] ex_me;
    logic [1:0] me_wb;
  } stall_vec_t;

  function automatic stall_vec_t stall_all(input logic [1:0] code);
    stall_vec_t v;
    v.pc    = code;
    v.if_id = code;
    v.id_ex = code;
    v.ex_me = code;
    v.me_wb = code;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_watchdog.sv
// Counts consecutive busy cycles and raises a sticky hang flag on the TIMEOUT-th one.
`default_nettype none
module pipe_watchdog #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic busy,
  output logic hang_err
);

  localparam int W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [W-1:0] LAST = W'(TIMEOUT - 1);

  logic [W-1:0] cnt_q, cnt_d;
  logic         hang_q, hang_d;

  // The counter parks at LAST so a long stall never wraps back to zero.
  always_comb begin
    cnt_d  = cnt_q;
    hang_d = hang_q;
    if (busy) begin
      if (cnt_q != LAST) cnt_d = cnt_q + W'(1);
      if (cnt_q == LAST) hang_d = 1'b1;
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      hang_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      hang_q <= hang_d;
    end
  end

  assign hang_err = hang_q;

endmodule
`default_nettype wire

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/stall controller: arbitrates memory wait, redirect, load-use and fetch wait.
`default_nettype none
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 1024,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               if_busy,
  input  logic               mem_busy,
  input  logic               id_load_use,
  input  logic               ex_redirect,
  input  logic [REG_BUS-1:0] ex_redirect_target,
  output logic [1:0]         stall_pc,
  output logic [1:0]         stall_if_id,
  output logic [1:0]         stall_id_ex,
  output logic [1:0]         stall_ex_me,
  output logic [1:0]         stall_me_wb,
  output logic               pc_redirect,
  output logic [REG_BUS-1:0] pc_redirect_target,
  output logic               hang_err,
  output logic [CNT_W-1:0]   stall_cycles
);

  logic [0:0]         state_q, state_d;
  logic [REG_BUS-1:0] pend_q, pend_d;
  logic [CNT_W-1:0]   cnt_q;
  stall_vec_t         stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PCTL_RUN;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    if (!mem_busy) begin
      if (state_q == PCTL_DRAIN) begin
        if (!if_busy) state_d = PCTL_RUN;
      end else if (ex_redirect && if_busy) begin
        state_d = PCTL_DRAIN;
        pend_d  = ex_redirect_target;
      end
    end
  end

  always_comb begin
    stall              = stall_all(STALL_NEXT);
    pc_redirect        = 1'b0;
    pc_redirect_target = '0;
    if (rst) begin
      stall = stall_all(STALL_ZERO);
    end else if (mem_busy) begin
      // EX stays frozen, so a concurrent redirect is simply re-presented later.
      stall       = stall_all(STALL_KEEP);
      stall.me_wb = STALL_ZERO;
    end else if (state_q == PCTL_DRAIN) begin
      stall.if_id = STALL_ZERO;
      stall.id_ex = STALL_ZERO;
      if (if_busy) begin
        stall.pc = STALL_KEEP;
      end else begin
        pc_redirect        = 1'b1;
        pc_redirect_target = pend_q;
      end
    end else if (ex_redirect) begin
      stall.if_id = STALL_ZERO;
      stall.id_ex = STALL_ZERO;
      if (if_busy) begin
        stall.pc = STALL_KEEP;
      end else begin
        pc_redirect        = 1'b1;
        pc_redirect_target = ex_redirect_target;
      end
    end else if (id_load_use) begin
      stall.pc    = STALL_KEEP;
      stall.if_id = STALL_KEEP;
      stall.id_ex = STALL_ZERO;
    end else if (if_busy) begin
      stall.pc    = STALL_KEEP;
      stall.if_id = STALL_ZERO;
    end
  end

  assign stall_pc    = stall.pc;
  assign stall_if_id = stall.if_id;
  assign stall_id_ex = stall.id_ex;
  assign stall_ex_me = stall.ex_me;
  assign stall_me_wb = stall.me_wb;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (stall.pc != STALL_NEXT) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign stall_cycles = cnt_q;

  pipe_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk      (clk),
    .rst      (rst),
    .busy     (if_busy | mem_busy),
    .hang_err (hang_err)
  );

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
// Directed and random checks of pipe_ctrl against a rule-level reference model.
`default_nettype none
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst, if_busy, mem_busy, id_load_use, ex_redirect;
  logic [63:0] ex_redirect_target;
  logic [1:0]  stall_pc, stall_if_id, stall_id_ex, stall_ex_me, stall_me_wb;
  logic        pc_redirect, hang_err;
  logic [63:0] pc_redirect_target;
  logic [31:0] stall_cycles;

  int errors = 0;
  int checks = 0;

  // Reference model state: pending-redirect flag, busy run length, totals.
  bit          m_drain;
  logic [63:0] m_pend;
  int          m_run;
  bit          m_hang;
  logic [31:0] m_cnt;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT(TO), .CNT_W(32)) dut (
    .clk                (clk),
    .rst                (rst),
    .if_busy            (if_busy),
    .mem_busy           (mem_busy),
    .id_load_use        (id_load_use),
    .ex_redirect        (ex_redirect),
    .ex_redirect_target (ex_redirect_target),
    .stall_pc           (stall_pc),
    .stall_if_id        (stall_if_id),
    .stall_id_ex        (stall_id_ex),
    .stall_ex_me        (stall_ex_me),
    .stall_me_wb        (stall_me_wb),
    .pc_redirect        (pc_redirect),
    .pc_redirect_target (pc_redirect_target),
    .hang_err           (hang_err),
    .stall_cycles       (stall_cycles)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_drain = 0;
    m_pend  = '0;
    m_run   = 0;
    m_hang  = 0;
    m_cnt   = '0;
  endtask

  task automatic cycle(input bit r, input bit ifb, input bit memb, input bit lu,
                       input bit red, input logic [63:0] tgt);
    logic [1:0]  e_pc, e_ifid, e_idex, e_exme, e_mewb;
    logic        e_red;
    logic [63:0] e_tgt;
    rst = r; if_busy = ifb; mem_busy = memb; id_load_use = lu;
    ex_redirect = red; ex_redirect_target = tgt;
    @(negedge clk);
    {e_pc, e_ifid, e_idex, e_exme, e_mewb} = {5{STALL_NEXT}};
    e_red = 0;
    e_tgt = '0;
    if (r) begin
      {e_pc, e_ifid, e_idex, e_exme, e_mewb} = {5{STALL_ZERO}};
    end else if (memb) begin
      {e_pc, e_ifid, e_idex, e_exme} = {4{STALL_KEEP}};
      e_mewb = STALL_ZERO;
    end else if (m_drain || red) begin
      e_ifid = STALL_ZERO;
      e_idex = STALL_ZERO;
      if (ifb) e_pc = STALL_KEEP;
      else begin
        e_red = 1;
        e_tgt = m_drain ? m_pend : tgt;
      end
    end else if (lu) begin
      e_pc = STALL_KEEP; e_ifid = STALL_KEEP; e_idex = STALL_ZERO;
    end else if (ifb) begin
      e_pc = STALL_KEEP; e_ifid = STALL_ZERO;
    end
    chk("stall_pc",     64'(stall_pc),    64'(e_pc));
    chk("stall_if_id",  64'(stall_if_id), 64'(e_ifid));
    chk("stall_id_ex",  64'(stall_id_ex), 64'(e_idex));
    chk("stall_ex_me",  64'(stall_ex_me), 64'(e_exme));
    chk("stall_me_wb",  64'(stall_me_wb), 64'(e_mewb));
    chk("pc_redirect",  64'(pc_redirect), 64'(e_red));
    chk("redir_target", pc_redirect_target, e_tgt);
    chk("hang_err",     64'(hang_err),    64'(m_hang));
    chk("stall_cycles", 64'(stall_cycles), 64'(m_cnt));
    @(posedge clk);
    if (r) begin
      model_reset();
    end else begin
      if (e_pc != STALL_NEXT) m_cnt = m_cnt + 1;
      m_run = (ifb || memb) ? m_run + 1 : 0;
      if (m_run >= TO) m_hang = 1;
      if (!memb) begin
        if (m_drain && !ifb) m_drain = 0;
        else if (!m_drain && red && ifb) begin
          m_drain = 1;
          m_pend  = tgt;
        end
      end
    end
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    rst = 1; if_busy = 0; mem_busy = 0; id_load_use = 0; ex_redirect = 0;
    ex_redirect_target = '0;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    cycle(1, 0, 0, 0, 0, 64'h0);

    // Plain flow
    repeat (5) cycle(0, 0, 0, 0, 0, 64'h0);
    // Load-use
    cycle(0, 0, 0, 1, 0, 64'h0);
    cycle(0, 0, 0, 0, 0, 64'h0);
    // Redirect with fetch idle
    cycle(0, 0, 0, 0, 1, 64'h8000_0100);
    cycle(0, 0, 0, 0, 0, 64'h0);
    // Redirect behind busy fetch
    cycle(0, 1, 0, 0, 1, 64'h8000_0200);
    cycle(0, 1, 0, 0, 0, 64'h0);
    cycle(0, 1, 0, 0, 0, 64'h0);
    cycle(0, 0, 0, 0, 0, 64'h0);
    cycle(0, 0, 0, 0, 0, 64'h0);
    // mem_busy overrides redirect
    cycle(0, 0, 1, 0, 1, 64'h8000_0300);
    cycle(0, 0, 1, 0, 1, 64'h8000_0300);
    cycle(0, 0, 0, 0, 1, 64'h8000_0300);
    // Reset in DRAIN drops the pending redirect
    cycle(0, 1, 0, 0, 1, 64'h8000_0400);
    cycle(1, 1, 0, 0, 0, 64'h0);
    cycle(0, 0, 0, 0, 0, 64'h0);
    // Watchdog: boundary at TIMEOUT busy cycles, sticky, cleared by reset
    repeat (TO + 2) cycle(0, 0, 1, 0, 0, 64'h0);
    repeat (2) cycle(0, 0, 0, 0, 0, 64'h0);
    cycle(1, 0, 0, 0, 0, 64'h0);
    cycle(0, 0, 0, 0, 0, 64'h0);
    // One short of TIMEOUT must not trip
    repeat (TO - 1) cycle(0, 1, 0, 0, 0, 64'h0);
    cycle(0, 0, 0, 0, 0, 64'h0);
    repeat (TO - 1) cycle(0, 0, 1, 0, 0, 64'h0);
    cycle(0, 1, 0, 0, 0, 64'h0);
    cycle(0, 0, 0, 0, 0, 64'h0);
    cycle(1, 0, 0, 0, 0, 64'h0);

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 99) < 2),
            ($urandom_range(0, 99) < 45),
            ($urandom_range(0, 99) < 20),
            ($urandom_range(0, 99) < 25),
            ($urandom_range(0, 99) < 25),
            {$urandom, $urandom});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline hazard/stall controller for the 5-stage RV64 core.
- Produces the 2-bit stall codes consumed by the pc register and by the if_id, id_ex, ex_me and me_wb pipeline registers: `STALL_NEXT` (advance), `STALL_KEEP` (hold), `STALL_ZERO` (insert bubble).
- Arbitrates memory-wait, branch-redirect, load-use and fetch-wait events.
- Holds a redirect pending while an in-flight fetch drains, and runs a hang watchdog and a stall-cycle counter.

Parameters:
- TIMEOUT, 1024: consecutive busy cycles before hang_err sets.
- CNT_W, 32: width of stall_cycles.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- if_busy  in  1  instruction fetch in flight, not complete this cycle
- mem_busy  in  1  MEM-stage data access not complete this cycle
- id_load_use  in  1  decode detected load-use hazard against EX
- ex_redirect  in  1  taken branch/jump resolved in EX
- ex_redirect_target  in  64  target PC for ex_redirect
- stall_pc  out  2  stall code for pc register
- stall_if_id  out  2  stall code for if_id
- stall_id_ex  out  2  stall code for id_ex
- stall_ex_me  out  2  stall code for ex_me
- stall_me_wb  out  2  stall code for me_wb
- pc_redirect  out  1  pc loads pc_redirect_target this cycle
- pc_redirect_target  out  64  redirect PC
- hang_err  out  1  sticky watchdog error
- stall_cycles  out  CNT_W  count of cycles with stall_pc != `STALL_NEXT`

Behaviour:
- One clock domain (clk); reset is synchronous and active-high (rst).
- While rst=1:
  - All five stall outputs are `STALL_ZERO`; pc_redirect=0; pc_redirect_target=0.
  - On the next edge: hang_err=0, stall_cycles=0, watchdog count=0, pend_target=0, state=RUN.
  - Reset mid-DRAIN abandons the pending redirect.
- Stall outputs, pc_redirect and pc_redirect_target are combinational from state and inputs, with zero latency. State, pend_target, counters and hang_err are registered.
- FSM states:
  - RUN: normal operation.
  - DRAIN: a redirect is pending behind an in-flight fetch.
- Priority in RUN, highest first:
  1. mem_busy: pc, if_id, id_ex, ex_me = KEEP; me_wb = ZERO, so WB sees a bubble and never double-commits. pc_redirect=0. Any ex_redirect waits, because EX is frozen and the input stays asserted.
  2. ex_redirect & !if_busy: pc=NEXT, pc_redirect=1, target=ex_redirect_target; if_id=ZERO; id_ex=ZERO; ex_me=NEXT; me_wb=NEXT.
  3. ex_redirect & if_busy: pc=KEEP; if_id=ZERO; id_ex=ZERO; ex_me=NEXT; me_wb=NEXT. pend_target<=ex_redirect_target; state<=DRAIN.
  4. id_load_use: pc=KEEP; if_id=KEEP; id_ex=ZERO; ex_me=NEXT; me_wb=NEXT.
  5. if_busy: pc=KEEP; if_id=ZERO; all other stages NEXT.
  6. Otherwise all stages NEXT.
- DRAIN:
  - mem_busy takes priority with the same codes as in RUN; state stays DRAIN.
  - Else if if_busy: pc=KEEP; if_id=ZERO; id_ex=ZERO; ex_me=NEXT; me_wb=NEXT.
  - Else (fetch completes, fetched word discarded): pc=NEXT, pc_redirect=1, target=pend_target; if_id=ZERO; id_ex=ZERO; ex_me=NEXT; me_wb=NEXT; state<=RUN.
  - ex_redirect and id_load_use are ignored in DRAIN, since the younger instructions are squashed.
- Watchdog:
  - Count increments each cycle (if_busy | mem_busy) is high; it clears on any cycle both are low.
  - When the count reaches TIMEOUT-1 while busy, hang_err<=1 and stays set until rst.
  - The count saturates and does not wrap.
- stall_cycles: +1 on each cycle with stall_pc != `STALL_NEXT` and rst=0; it wraps modulo 2^CNT_W.

Decomposition:
- defines.v holds `STALL_NEXT`, `STALL_KEEP`, `STALL_ZERO` (2-bit, already shared by the pipeline registers), `REG_BUS`, and the new state encodings `PCTL_RUN` and `PCTL_DRAIN`.
- One natural sub-module, pipe_watchdog (busy counter plus sticky hang_err, parameter TIMEOUT). The rest stays flat.

Test Plan:
1. Plain flow:
   - Stimulus: all inputs 0 for 5 cycles.
   - Response: all stall outputs NEXT, pc_redirect=0, stall_cycles=0.
2. Load-use:
   - Stimulus: id_load_use=1 for 1 cycle.
   - Response: pc=KEEP, if_id=KEEP, id_ex=ZERO, ex_me=NEXT, me_wb=NEXT; stall_cycles becomes 1.
3. Redirect, fetch idle:
   - Stimulus: ex_redirect=1, target=0x8000_0100, if_busy=0.
   - Response: pc_redirect=1, pc_redirect_target=0x8000_0100, if_id=ZERO, id_ex=ZERO, state stays RUN.
4. Redirect behind busy fetch:
   - Stimulus: ex_redirect=1, target=0x8000_0200, with if_busy=1 for 3 cycles (the redirect is dropped after the first cycle).
   - Response: pc=KEEP and if_id=ZERO for those 3 cycles, then on the next cycle pc_redirect=1 with target 0x8000_0200 and state returns to RUN.
5. mem_busy overrides redirect:
   - Stimulus: mem_busy=1 and ex_redirect=1 for 2 cycles, then mem_busy=0.
   - Response: first 2 cycles pc..ex_me=KEEP, me_wb=ZERO, pc_redirect=0. Third cycle pc_redirect=1.
6. Watchdog and reset:
   - Stimulus: TIMEOUT=8, mem_busy held high.
   - Response: hang_err=1 after the 8th busy cycle and stays 1 after mem_busy drops. Asserting rst clears hang_err, stall_cycles and state.
